// File: rtl/control_pipeline_pkg.sv
// ----------------------------------------------------------------------------
// control_pipeline_pkg
//   Shared definitions for the execute-side control pipeline:
//   - ARM condition-field encodings (Instr[31:28])
//   - NZCV bit positions within the flags register
//   - packed control bundles carried by each pipeline register
// ----------------------------------------------------------------------------
package control_pipeline_pkg;

  // ARM condition field encodings.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the 4-bit NZCV register.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Everything the D->E register holds. An all-zero value is a bubble.
  typedef struct packed {
    logic [3:0] cond;
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [1:0] alu_control;
    logic       branch;
    logic       alusrc;
    logic [1:0] flagwrite;
  } ctrl_e_t;

  // E->M register contents (write enables already condition-gated).
  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic pcsrc;
  } ctrl_m_t;

  // M->W register contents.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } ctrl_w_t;

endpackage

// File: rtl/control_pipeline_cond_check.sv
// ----------------------------------------------------------------------------
// cond_check
//   Purely combinational condition evaluation for the Execute stage.
//   Decides whether the instruction in E executes, and computes the value
//   the NZCV register takes at the end of this E cycle.
//
// Ports:
//   i_cond        in  4  condition field of the instruction in E
//   i_flags       in  4  current NZCV register (before this instruction)
//   i_flag_write  in  2  [1]=update N,Z  [0]=update C,V
//   i_alu_flags   in  4  NZCV produced by the ALU this cycle
//   o_cond_ex     out 1  condition passed
//   o_flags_next  out 4  NZCV value to load at the next rising edge
// ----------------------------------------------------------------------------
module cond_check
  import control_pipeline_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  input  logic [1:0] i_flag_write,
  input  logic [3:0] i_alu_flags,
  output logic       o_cond_ex,
  output logic [3:0] o_flags_next
);

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ex;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred even if an encoding were ever left out of the case list.
    w_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = !w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = !w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = !w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = !w_v;
      COND_HI: w_cond_ex = w_c & !w_z;
      COND_LS: w_cond_ex = !w_c | w_z;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = !w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_AL: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // NV: never executes
    endcase
  end

  // The N,Z and C,V halves are written independently; a failed condition
  // suppresses both.
  always_comb begin
    o_flags_next = i_flags;
    if (i_flag_write[1] && w_cond_ex) begin
      o_flags_next[FLAG_N] = i_alu_flags[FLAG_N];
      o_flags_next[FLAG_Z] = i_alu_flags[FLAG_Z];
    end
    if (i_flag_write[0] && w_cond_ex) begin
      o_flags_next[FLAG_C] = i_alu_flags[FLAG_C];
      o_flags_next[FLAG_V] = i_alu_flags[FLAG_V];
    end
  end

  assign o_cond_ex = w_cond_ex;

endmodule

// File: rtl/control_pipeline.sv
// ----------------------------------------------------------------------------
// control_pipeline
//   Carries the decode-stage control bundle through the D->E, E->M and M->W
//   pipeline registers, owns the NZCV flags register, evaluates the ARM
//   condition field in Execute and squashes the state-changing controls of
//   condition-failed instructions.
//
// Build option:
//   CTRL_SQUASH_CNT_EN  when defined, SquashCnt counts (saturating) the cycles
//                       in which E holds a condition-failed instruction that
//                       would have changed state. Otherwise SquashCnt is 0.
//
// Parameters:
//   FLAGS_RST  reset value of NZCV (bit3=N, bit2=Z, bit1=C, bit0=V)
//   CNT_W      width of the squash counter
//
// Ports:
//   clk, reset (async, active-high)
//   FlushE                       bubble into the D->E register
//   CondD, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, ALUControlD, BranchD,
//   ALUSrcD, FlagWriteD          decode-stage controls
//   ALUFlagsE                    NZCV from the Execute ALU
//   ALUControlE, ALUSrcE, MemtoRegE, PCSrcE, BranchTakenE   Execute outputs
//   RegWriteM, MemWriteM, MemtoRegM, PCSrcM                 Memory outputs
//   RegWriteW, MemtoRegW, PCSrcW                            Writeback outputs
//   FlagsQ                       current NZCV register
//   SquashCnt                    squash counter (0 when the option is off)
// ----------------------------------------------------------------------------
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlushE,
  input  logic [3:0]       CondD,
  input  logic             PCSrcD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic [1:0]       ALUControlD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       FlagWriteD,
  input  logic [3:0]       ALUFlagsE,
  output logic [1:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic             MemtoRegE,
  output logic             PCSrcE,
  output logic             BranchTakenE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic             PCSrcW,
  output logic [3:0]       FlagsQ,
  output logic [CNT_W-1:0] SquashCnt
);

  ctrl_e_t    r_de;
  ctrl_m_t    r_em;
  ctrl_w_t    r_mw;
  logic [3:0] r_flags;

  ctrl_e_t    w_de_next;
  ctrl_m_t    w_em_next;
  logic       w_cond_ex;
  logic [3:0] w_flags_next;
  logic       w_regwrite_ge;
  logic       w_memwrite_ge;
  logic       w_pcsrc_ge;

  // ---------------------------------------------------------------- D -> E
  // A flush only replaces what is being captured; the instruction already in
  // E still completes, including its flag update.
  always_comb begin
    w_de_next             = '0;
    if (!FlushE) begin
      w_de_next.cond        = CondD;
      w_de_next.pcsrc       = PCSrcD;
      w_de_next.regwrite    = RegWriteD;
      w_de_next.memtoreg    = MemtoRegD;
      w_de_next.memwrite    = MemWriteD;
      w_de_next.alu_control = ALUControlD;
      w_de_next.branch      = BranchD;
      w_de_next.alusrc      = ALUSrcD;
      w_de_next.flagwrite   = FlagWriteD;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_de <= '0;
    else       r_de <= w_de_next;
  end

  // ---------------------------------------------------------------- Execute
  cond_check u_cond_check (
    .i_cond       (r_de.cond),
    .i_flags      (r_flags),
    .i_flag_write (r_de.flagwrite),
    .i_alu_flags  (ALUFlagsE),
    .o_cond_ex    (w_cond_ex),
    .o_flags_next (w_flags_next)
  );

  assign w_pcsrc_ge    = r_de.pcsrc    & w_cond_ex;
  assign w_regwrite_ge = r_de.regwrite & w_cond_ex;
  assign w_memwrite_ge = r_de.memwrite & w_cond_ex;

  assign ALUControlE  = r_de.alu_control;
  assign ALUSrcE      = r_de.alusrc;
  assign MemtoRegE    = r_de.memtoreg;  // ungated: hazard unit needs it raw
  assign PCSrcE       = w_pcsrc_ge;
  assign BranchTakenE = r_de.branch & w_cond_ex;

  // Condition is evaluated against r_flags, so an instruction never sees its
  // own flag update; the next one in E does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_flags <= FLAGS_RST;
    else       r_flags <= w_flags_next;
  end

  assign FlagsQ = r_flags;

  // ---------------------------------------------------------------- E -> M
  always_comb begin
    w_em_next          = '0;
    w_em_next.regwrite = w_regwrite_ge;
    w_em_next.memwrite = w_memwrite_ge;
    w_em_next.memtoreg = r_de.memtoreg;
    w_em_next.pcsrc    = w_pcsrc_ge;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_em <= '0;
    else       r_em <= w_em_next;
  end

  assign RegWriteM = r_em.regwrite;
  assign MemWriteM = r_em.memwrite;
  assign MemtoRegM = r_em.memtoreg;
  assign PCSrcM    = r_em.pcsrc;

  // ---------------------------------------------------------------- M -> W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mw <= '0;
    end else begin
      r_mw.regwrite <= r_em.regwrite;
      r_mw.memtoreg <= r_em.memtoreg;
      r_mw.pcsrc    <= r_em.pcsrc;
    end
  end

  assign RegWriteW = r_mw.regwrite;
  assign MemtoRegW = r_mw.memtoreg;
  assign PCSrcW    = r_mw.pcsrc;

  // ---------------------------------------------------------- squash count
`ifdef CTRL_SQUASH_CNT_EN
  logic [CNT_W-1:0] r_squash_cnt;
  logic             w_squash;

  // A squash is only interesting if the failed instruction would have
  // changed architectural or control-flow state.
  assign w_squash = !w_cond_ex &
                    (r_de.regwrite | r_de.memwrite | r_de.pcsrc |
                     r_de.branch   | (|r_de.flagwrite));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_squash_cnt <= '0;
    end else if (w_squash && (r_squash_cnt != '1)) begin
      r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign SquashCnt = r_squash_cnt;
`else
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// ----------------------------------------------------------------------------
// tb_control_pipeline
//   Directed, self-checking bench for control_pipeline. Each scenario task
//   drives its stimulus and compares outputs against hand-computed values.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_control_pipeline;

  localparam int CNT_W = 16;

`ifdef CTRL_SQUASH_CNT_EN
  localparam logic [CNT_W-1:0] EXP_SQ_ONE = 16'd1;
`else
  localparam logic [CNT_W-1:0] EXP_SQ_ONE = 16'd0;
`endif

  logic             clk;
  logic             reset;
  logic             FlushE;
  logic [3:0]       CondD;
  logic             PCSrcD, RegWriteD, MemtoRegD, MemWriteD;
  logic [1:0]       ALUControlD;
  logic             BranchD, ALUSrcD;
  logic [1:0]       FlagWriteD;
  logic [3:0]       ALUFlagsE;
  logic [1:0]       ALUControlE;
  logic             ALUSrcE, MemtoRegE, PCSrcE, BranchTakenE;
  logic             RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic             RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0]       FlagsQ;
  logic [CNT_W-1:0] SquashCnt;

  int total = 0;
  int bad   = 0;

  control_pipeline #(.FLAGS_RST(4'b0000), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .FlushE       (FlushE),
    .CondD        (CondD),
    .PCSrcD       (PCSrcD),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .MemWriteD    (MemWriteD),
    .ALUControlD  (ALUControlD),
    .BranchD      (BranchD),
    .ALUSrcD      (ALUSrcD),
    .FlagWriteD   (FlagWriteD),
    .ALUFlagsE    (ALUFlagsE),
    .ALUControlE  (ALUControlE),
    .ALUSrcE      (ALUSrcE),
    .MemtoRegE    (MemtoRegE),
    .PCSrcE       (PCSrcE),
    .BranchTakenE (BranchTakenE),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .MemtoRegM    (MemtoRegM),
    .PCSrcM       (PCSrcM),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .FlagsQ       (FlagsQ),
    .SquashCnt    (SquashCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {flags, cond, expected CondEx}
  logic [8:0] cond_vec [21] = '{
    {4'b0100, 4'b0000, 1'b1}, {4'b0000, 4'b0000, 1'b0},
    {4'b0000, 4'b0001, 1'b1}, {4'b0010, 4'b0010, 1'b1},
    {4'b0010, 4'b0011, 1'b0}, {4'b1000, 4'b0100, 1'b1},
    {4'b1000, 4'b0101, 1'b0}, {4'b0001, 4'b0110, 1'b1},
    {4'b0001, 4'b0111, 1'b0}, {4'b0010, 4'b1000, 1'b1},
    {4'b0110, 4'b1000, 1'b0}, {4'b0110, 4'b1001, 1'b1},
    {4'b0010, 4'b1001, 1'b0}, {4'b1001, 4'b1010, 1'b1},
    {4'b1000, 4'b1011, 1'b1}, {4'b0000, 4'b1100, 1'b1},
    {4'b0100, 4'b1100, 1'b0}, {4'b0001, 4'b1101, 1'b1},
    {4'b0000, 4'b1101, 1'b0}, {4'b0000, 4'b1110, 1'b1},
    {4'b1111, 4'b1111, 1'b0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    FlushE      = 1'b0;
    CondD       = 4'b0000;
    PCSrcD      = 1'b0;
    RegWriteD   = 1'b0;
    MemtoRegD   = 1'b0;
    MemWriteD   = 1'b0;
    ALUControlD = 2'b00;
    BranchD     = 1'b0;
    ALUSrcD     = 1'b0;
    FlagWriteD  = 2'b00;
  endtask

  task automatic reset_dut();
    clear_d();
    ALUFlagsE = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    clear_d();
    ALUFlagsE = 4'b0000;
    reset = 1'b1;
    #1;
    outs = {ALUControlE, ALUSrcE, MemtoRegE, PCSrcE, BranchTakenE, RegWriteM,
            MemWriteM, MemtoRegM, PCSrcM, RegWriteW, MemtoRegW, PCSrcW, 1'b0};
    total++;
    if (outs !== 14'd0) begin
      $display("FAIL reset_outs: got %b want all zero", outs); bad++;
    end
    total++;
    if (FlagsQ !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", FlagsQ); bad++;
    end
    total++;
    if (SquashCnt !== '0) begin
      $display("FAIL reset_squash: got %0d want 0", SquashCnt); bad++;
    end
    tick();
    reset = 1'b0;
    // Put a flag-setting register write in flight, then reset mid-cycle.
    CondD = 4'b1110; RegWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    clear_d();
    ALUFlagsE = 4'b1010;
    tick();
    ALUFlagsE = 4'b0000;
    total++;
    if (FlagsQ !== 4'b1010 || RegWriteM !== 1'b1) begin
      $display("FAIL reset_prefill: got flags=%b rwm=%b want 1010/1", FlagsQ, RegWriteM); bad++;
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (RegWriteM !== 1'b0 || FlagsQ !== 4'b0000) begin
      $display("FAIL reset_async: got rwm=%b flags=%b want 0/0000", RegWriteM, FlagsQ); bad++;
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (RegWriteW !== 1'b0) begin
      $display("FAIL reset_w_cleared: got %b want 0", RegWriteW); bad++;
    end
  endtask

  task automatic test_cmp_beq();
    reset_dut();
    CondD = 4'b1110; FlagWriteD = 2'b11;       // CMP, AL
    tick();
    ALUFlagsE = 4'b0100;
    clear_d();
    BranchD = 1'b1; CondD = 4'b0000;           // BEQ
    total++;
    if (FlagsQ !== 4'b0000) begin
      $display("FAIL cmp_own_flags: got %b want 0000", FlagsQ); bad++;
    end
    tick();
    ALUFlagsE = 4'b0000;
    clear_d();
    total++;
    if (FlagsQ !== 4'b0100) begin
      $display("FAIL cmp_flags: got %b want 0100", FlagsQ); bad++;
    end
    total++;
    if (BranchTakenE !== 1'b1) begin
      $display("FAIL beq_taken: got %b want 1", BranchTakenE); bad++;
    end
    tick();
    total++;
    if (BranchTakenE !== 1'b0) begin
      $display("FAIL beq_after: got %b want 0", BranchTakenE); bad++;
    end
  endtask

  task automatic test_conditions();
    logic [8:0] v;
    reset_dut();
    for (int i = 0; i < 21; i++) begin
      v = cond_vec[i];
      clear_d();
      CondD = 4'b1110; FlagWriteD = 2'b11;     // load flags
      tick();
      ALUFlagsE = v[8:5];
      clear_d();
      BranchD = 1'b1; PCSrcD = 1'b1; CondD = v[4:1];
      tick();
      ALUFlagsE = 4'b0000;
      total++;
      if (BranchTakenE !== v[0] || PCSrcE !== v[0]) begin
        $display("FAIL cond_%0d: flags=%b cond=%b got bt=%b pcs=%b want %b",
                 i, v[8:5], v[4:1], BranchTakenE, PCSrcE, v[0]);
        bad++;
      end
    end
    clear_d();
  endtask

  task automatic test_failed_cond();
    reset_dut();
    CondD = 4'b0000; RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1;
    tick();
    clear_d();
    total++;
    if (MemtoRegE !== 1'b1 || PCSrcE !== 1'b0) begin
      $display("FAIL fail_e: got mte=%b pcse=%b want 1/0", MemtoRegE, PCSrcE); bad++;
    end
    tick();
    total++;
    if ({RegWriteM, MemWriteM, MemtoRegM} !== 3'b001) begin
      $display("FAIL fail_m: got rw/mw/mtr=%b want 001", {RegWriteM, MemWriteM, MemtoRegM}); bad++;
    end
    total++;
    if (SquashCnt !== EXP_SQ_ONE) begin
      $display("FAIL fail_squash: got %0d want %0d", SquashCnt, EXP_SQ_ONE); bad++;
    end
    tick();
    total++;
    if ({RegWriteW, MemtoRegW} !== 2'b01) begin
      $display("FAIL fail_w: got rw/mtr=%b want 01", {RegWriteW, MemtoRegW}); bad++;
    end
    total++;
    if (SquashCnt !== EXP_SQ_ONE) begin
      $display("FAIL fail_squash_hold: got %0d want %0d", SquashCnt, EXP_SQ_ONE); bad++;
    end
  endtask

  task automatic test_partial_flags();
    reset_dut();
    CondD = 4'b1110; FlagWriteD = 2'b11;
    tick();
    ALUFlagsE = 4'b1111;
    clear_d();
    CondD = 4'b1110; FlagWriteD = 2'b10;       // N,Z only
    tick();
    ALUFlagsE = 4'b0000;
    clear_d();
    total++;
    if (FlagsQ !== 4'b1111) begin
      $display("FAIL partial_setup: got %b want 1111", FlagsQ); bad++;
    end
    CondD = 4'b0000; FlagWriteD = 2'b11;       // EQ fails with Z=0
    tick();
    ALUFlagsE = 4'b1100;
    clear_d();
    total++;
    if (FlagsQ !== 4'b0011) begin
      $display("FAIL partial_nz: got %b want 0011", FlagsQ); bad++;
    end
    CondD = 4'b1110; FlagWriteD = 2'b01;       // C,V only
    tick();
    ALUFlagsE = 4'b1000;
    clear_d();
    total++;
    if (FlagsQ !== 4'b0011) begin
      $display("FAIL failed_flagwrite: got %b want 0011", FlagsQ); bad++;
    end
    tick();
    ALUFlagsE = 4'b0000;
    total++;
    if (FlagsQ !== 4'b0000) begin
      $display("FAIL partial_cv: got %b want 0000", FlagsQ); bad++;
    end
  endtask

  task automatic test_flush();
    reset_dut();
    CondD = 4'b1110; PCSrcD = 1'b1; FlushE = 1'b1;
    tick();
    clear_d();
    total++;
    if (PCSrcE !== 1'b0) begin
      $display("FAIL flush_e: got %b want 0", PCSrcE); bad++;
    end
    tick();
    total++;
    if (PCSrcM !== 1'b0) begin
      $display("FAIL flush_m: got %b want 0", PCSrcM); bad++;
    end
    tick();
    total++;
    if (PCSrcW !== 1'b0) begin
      $display("FAIL flush_w: got %b want 0", PCSrcW); bad++;
    end
    // Flag-setting instruction in E while the incoming capture is flushed.
    CondD = 4'b1110; FlagWriteD = 2'b11;
    tick();
    ALUFlagsE = 4'b1001;
    clear_d();
    CondD = 4'b1110; RegWriteD = 1'b1; FlushE = 1'b1;
    tick();
    ALUFlagsE = 4'b0000;
    clear_d();
    total++;
    if (FlagsQ !== 4'b1001) begin
      $display("FAIL flush_flags: got %b want 1001", FlagsQ); bad++;
    end
    tick();
    total++;
    if (RegWriteM !== 1'b0) begin
      $display("FAIL flush_rw: got %b want 0", RegWriteM); bad++;
    end
  endtask

  task automatic test_pipeline_timing();
    reset_dut();
    CondD = 4'b1110; RegWriteD = 1'b1; PCSrcD = 1'b1;
    ALUControlD = 2'b10; ALUSrcD = 1'b1;
    tick();                                    // cycle 1: in E
    clear_d();
    total++;
    if ({ALUControlE, ALUSrcE, PCSrcE, RegWriteM} !== 5'b10110) begin
      $display("FAIL timing_e: got %b want 10110", {ALUControlE, ALUSrcE, PCSrcE, RegWriteM}); bad++;
    end
    tick();                                    // cycle 2: in M
    total++;
    if ({RegWriteM, PCSrcM, RegWriteW} !== 3'b110) begin
      $display("FAIL timing_m: got %b want 110", {RegWriteM, PCSrcM, RegWriteW}); bad++;
    end
    tick();                                    // cycle 3: in W
    total++;
    if ({RegWriteW, PCSrcW, RegWriteM} !== 3'b110) begin
      $display("FAIL timing_w: got %b want 110", {RegWriteW, PCSrcW, RegWriteM}); bad++;
    end
    CondD = 4'b1111; RegWriteD = 1'b1;         // never executes
    tick();
    clear_d();
    tick();
    total++;
    if (RegWriteM !== 1'b0) begin
      $display("FAIL timing_nv_m: got %b want 0", RegWriteM); bad++;
    end
    tick();
    total++;
    if (RegWriteW !== 1'b0) begin
      $display("FAIL timing_nv_w: got %b want 0", RegWriteW); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_cmp_beq();
    test_conditions();
    test_failed_cond();
    test_partial_flags();
    test_flush();
    test_pipeline_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
